// File: rtl/vga_layer_ctrl.sv
// vga_layer_ctrl: parametrised VGA timing generator with an internal pixel-enable
// divider, fixed-priority compositing of NLAYER colour sources over a background
// colour, and a CPU register file whose control writes are applied at vblank entry.
module vga_layer_ctrl #(
   parameter int PIX_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int NLAYER   = 3,
   parameter int CW       = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we_reg,
   input  logic                       rd_reg,
   input  logic [1:0]                 reg_addr,
   input  logic [31:0]                data_in,
   output logic [31:0]                data_out,
   input  logic [NLAYER*3*CW-1:0]     layer_color,
   input  logic [NLAYER-1:0]          layer_valid,
   output logic [9:0]                 column,
   output logic [9:0]                 row,
   output logic [CW-1:0]              r,
   output logic [CW-1:0]              g,
   output logic [CW-1:0]              b,
   output logic                       hsync,
   output logic                       vsync,
   output logic                       busy,
   output logic                       vblank_irq
);
   localparam int PW    = 3*CW;
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW    = $clog2(PIX_DIV);

   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0]     r_div;
   logic [9:0]        r_h, r_v;
   logic              r_busy, r_hs, r_vs;
   logic [PW-1:0]     r_rgb;
   // shadow (CPU-visible) and active (display-visible) control copies
   logic [NLAYER-1:0] r_sh_en, r_en;
   logic              r_sh_blank, r_blank, r_sh_irqen, r_irqen;
   logic [PW-1:0]     r_sh_bg, r_bg;
   logic              r_pending, r_irq_pend;
   logic [31:0]       r_frame;

   logic              w_pix_ce, w_act, w_vblank, w_vbl_entry;
   logic              w_wr_ctrl, w_wr_stat, w_wr_bg;
   logic [PW-1:0]     w_pix;
   logic              w_unused;

   assign w_pix_ce    = (r_div == DIV_LAST);
   assign w_act       = (r_h < H_ACT) && (r_v < V_ACT);
   assign w_vblank    = (r_v >= V_ACT);
   // stage 0 is about to step from the last pixel of the last active line
   assign w_vbl_entry = w_pix_ce && (r_h == H_LAST) && (r_v == V_ACT_M1);
   assign w_wr_ctrl   = we_reg && (reg_addr == 2'd0);
   assign w_wr_stat   = we_reg && (reg_addr == 2'd1);
   assign w_wr_bg     = we_reg && (reg_addr == 2'd3);
   assign w_unused    = ^data_in;

   assign column     = r_h;
   assign row        = r_v;
   assign busy       = r_busy;
   assign hsync      = r_hs;
   assign vsync      = r_vs;
   assign r          = r_rgb[PW-1 -: CW];
   assign g          = r_rgb[2*CW-1 -: CW];
   assign b          = r_rgb[CW-1:0];
   assign vblank_irq = r_irq_pend & r_irqen;

   // pixel-enable divider: one pix_ce every PIX_DIV clocks
   always_ff @(posedge clk) begin
      if (rst)           r_div <= '0;
      else if (w_pix_ce) r_div <= '0;
      else               r_div <= r_div + DW'(1);
   end

   // stage 0: raster position counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (w_pix_ce) begin
         if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
         end else begin
            r_h <= r_h + 10'd1;
         end
      end
   end

   // composite: highest-index enabled opaque layer, else background; black when blanked
   always_comb begin
      w_pix = r_bg;
      for (int i = 0; i < NLAYER; i++)
         if (r_en[i] && layer_valid[i]) w_pix = layer_color[i*PW +: PW];
      if (!w_act || r_blank) w_pix = '0;
   end

   // stage 1: sync, busy and colour for the stage-0 coordinate
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_hs   <= ~SYNC_POL;
         r_vs   <= ~SYNC_POL;
         r_rgb  <= '0;
      end else if (w_pix_ce) begin
         r_busy <= w_act;
         r_hs   <= (r_h >= HS_BEG && r_h < HS_END) ? SYNC_POL : ~SYNC_POL;
         r_vs   <= (r_v >= VS_BEG && r_v < VS_END) ? SYNC_POL : ~SYNC_POL;
         r_rgb  <= w_pix;
      end
   end

   // register file; ordering gives irq-set priority over clear and lets a
   // write coincident with vblank entry land in the shadow after the transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sh_en    <= '0;
         r_en       <= '0;
         r_sh_blank <= 1'b0;
         r_blank    <= 1'b0;
         r_sh_irqen <= 1'b0;
         r_irqen    <= 1'b0;
         r_sh_bg    <= '0;
         r_bg       <= '0;
         r_pending  <= 1'b0;
         r_irq_pend <= 1'b0;
         r_frame    <= '0;
      end else begin
         if (w_wr_stat && data_in[2]) r_irq_pend <= 1'b0;
         if (w_vbl_entry) begin
            if (r_pending) begin
               r_en    <= r_sh_en;
               r_blank <= r_sh_blank;
               r_irqen <= r_sh_irqen;
               r_bg    <= r_sh_bg;
            end
            r_pending  <= 1'b0;
            r_frame    <= r_frame + 32'd1;
            r_irq_pend <= 1'b1;
         end
         if (w_wr_ctrl) begin
            r_sh_en    <= data_in[NLAYER-1:0];
            r_sh_blank <= data_in[8];
            r_sh_irqen <= data_in[9];
            r_pending  <= 1'b1;
         end
         if (w_wr_bg) begin
            r_sh_bg   <= data_in[PW-1:0];
            r_pending <= 1'b1;
         end
      end
   end

   // combinational register read mux
   always_comb begin
      data_out = '0;
      if (rd_reg) begin
         case (reg_addr)
            2'd0: begin
               data_out[NLAYER-1:0] = r_sh_en;
               data_out[8]          = r_sh_blank;
               data_out[9]          = r_sh_irqen;
            end
            2'd1:    data_out[2:0]    = {r_irq_pend, r_pending, w_vblank};
            2'd2:    data_out         = r_frame;
            default: data_out[PW-1:0] = r_sh_bg;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_layer_ctrl.sv
// Bench for vga_layer_ctrl on a tiny raster: the expected raster position is
// derived arithmetically from clocks since reset; register state is tracked
// as events (writes, vblank entries) in a small model.
module tb_vga_layer_ctrl;
   localparam int PD = 2;
   localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
   localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
   localparam int NL = 3, CW = 4, PW = 3*CW;
   localparam int HT = HA+HFP+HSW+HBP, VT = VA+VFP+VSW+VBP;
   localparam int FCLK = HT*VT*PD;

   logic clk = 1'b0, rst = 1'b1, we_reg = 1'b0, rd_reg = 1'b0;
   logic [1:0] reg_addr = '0;
   logic [31:0] data_in = '0, data_out;
   logic [NL*PW-1:0] layer_color = '0;
   logic [NL-1:0] layer_valid = '0;
   logic [9:0] column, row;
   logic [CW-1:0] r, g, b;
   logic hsync, vsync, busy, vblank_irq;

   int n_chk = 0, n_err = 0;

   // model state
   int mt;
   logic [NL-1:0] m_sh_en, m_en;
   logic m_sh_blank, m_blank, m_sh_irqen, m_irqen, m_pend, m_irqp, m_busy, m_hs, m_vs;
   logic [PW-1:0] m_sh_bg, m_bg, m_rgb;
   logic [31:0] m_frame;

   vga_layer_ctrl #(.PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1'b0),
      .NLAYER(NL), .CW(CW)) dut (
      .clk(clk), .rst(rst), .we_reg(we_reg), .rd_reg(rd_reg), .reg_addr(reg_addr),
      .data_in(data_in), .data_out(data_out), .layer_color(layer_color),
      .layer_valid(layer_valid), .column(column), .row(row), .r(r), .g(g), .b(b),
      .hsync(hsync), .vsync(vsync), .busy(busy), .vblank_irq(vblank_irq));

   always #5 clk = ~clk;

   function automatic int cur_h(); return (mt / PD) % HT; endfunction
   function automatic int cur_v(); return (mt / PD / HT) % VT; endfunction
   function automatic bit vbl_next();
      return ((mt + 1) % PD == 0) && cur_h() == HT-1 && cur_v() == VA-1;
   endfunction

   function automatic logic [35:0] obs();
      return {column, row, hsync, vsync, busy, r, g, b, vblank_irq};
   endfunction
   function automatic logic [35:0] exp_vec();
      return {10'(cur_h()), 10'(cur_v()), ~m_hs, ~m_vs, m_busy, m_rgb, m_irqp & m_irqen};
   endfunction
   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      case (a)
         2'd0: return {22'd0, m_sh_irqen, m_sh_blank, 5'd0, m_sh_en};
         2'd1: return {29'd0, m_irqp, m_pend, logic'(cur_v() >= VA)};
         2'd2: return m_frame;
         default: return {20'd0, m_sh_bg};
      endcase
   endfunction

   // one clock: advance DUT and model together, then settle for sampling
   task automatic tick();
      int h, v; bit ce, vbl; logic [PW-1:0] c;
      h = cur_h(); v = cur_v();
      ce = ((mt + 1) % PD) == 0;
      vbl = vbl_next();
      @(posedge clk);
      if (rst) begin
         mt = 0; m_sh_en = '0; m_en = '0; m_sh_blank = 0; m_blank = 0; m_sh_irqen = 0;
         m_irqen = 0; m_pend = 0; m_irqp = 0; m_busy = 0; m_hs = 0; m_vs = 0;
         m_sh_bg = '0; m_bg = '0; m_rgb = '0; m_frame = '0;
      end else begin
         if (ce) begin
            m_busy = (h < HA) && (v < VA);
            m_hs = (h >= HA+HFP) && (h < HA+HFP+HSW);
            m_vs = (v >= VA+VFP) && (v < VA+VFP+VSW);
            c = m_bg;
            for (int i = NL-1; i >= 0; i--)
               if (m_en[i] && layer_valid[i]) begin c = layer_color[i*PW +: PW]; break; end
            m_rgb = (!m_busy || m_blank) ? '0 : c;
         end
         if (we_reg && reg_addr == 2'd1 && data_in[2]) m_irqp = 0;
         if (vbl) begin
            if (m_pend) begin
               m_en = m_sh_en; m_blank = m_sh_blank; m_irqen = m_sh_irqen; m_bg = m_sh_bg;
            end
            m_pend = 0; m_frame++; m_irqp = 1;
         end
         if (we_reg && reg_addr == 2'd0) begin
            m_sh_en = data_in[NL-1:0]; m_sh_blank = data_in[8]; m_sh_irqen = data_in[9]; m_pend = 1;
         end
         if (we_reg && reg_addr == 2'd3) begin m_sh_bg = data_in[PW-1:0]; m_pend = 1; end
         mt++;
      end
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we_reg = 1; reg_addr = a; data_in = d;
      tick();
      we_reg = 0; data_in = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      rd_reg = 1; reg_addr = a;
      #1 d = data_out;
      rd_reg = 0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1; repeat (3) tick();
      n_chk++;
      if (obs() !== 36'h0_0000_0C00_0 >> 0 && obs() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0}) begin
         n_err++; $display("FAIL reset_outputs got %h exp %h", obs(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0});
      end
      rd(2'd2, d);
      n_chk++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_frame got %0d exp 0", d); end
      rst = 0;
      for (int k = 1; k < PD; k++) begin
         tick();
         n_chk++; if (column !== 10'd0) begin n_err++; $display("FAIL reset_first_ce col=%0d exp 0", column); end
      end
      tick();
      n_chk++; if (column !== 10'd1) begin n_err++; $display("FAIL reset_first_ce col=%0d exp 1", column); end
   endtask

   task automatic test_timing();
      int hs_low = 0, vs_low = 0, hrun = 0, vrun = 0;
      rst = 1; tick(); rst = 0;
      for (int i = 1; i <= 2*FCLK; i++) begin
         tick();
         n_chk++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL timing t=%0d got %h exp %h", i, obs(), exp_vec()); end
         if (!hsync) begin hs_low++; hrun++; end
         else if (hrun != 0) begin
            n_chk++; if (hrun != 2*PD) begin n_err++; $display("FAIL hsync_width got %0d exp %0d", hrun, 2*PD); end
            hrun = 0;
         end
         if (!vsync) begin vs_low++; vrun++; end
         else if (vrun != 0) begin
            n_chk++; if (vrun != HT*PD) begin n_err++; $display("FAIL vsync_width got %0d exp %0d", vrun, HT*PD); end
            vrun = 0;
         end
         if (i == FCLK) begin
            n_chk++;
            if (column !== 10'd0 || row !== 10'd0) begin n_err++; $display("FAIL frame_wrap col=%0d row=%0d exp 0,0", column, row); end
         end
      end
      n_chk++; if (hs_low != 2*VT*2*PD) begin n_err++; $display("FAIL hsync_total got %0d exp %0d", hs_low, 2*VT*2*PD); end
      n_chk++; if (vs_low != 2*HT*PD) begin n_err++; $display("FAIL vsync_total got %0d exp %0d", vs_low, 2*HT*PD); end
   endtask

   // hold a valid pattern until an active pixel sampled with it is shown
   task automatic show_pattern(input logic [NL-1:0] p, input logic [PW-1:0] e, input string nm);
      int k = 0; bit seen = 0;
      layer_valid = p;
      for (int i = 0; i < FCLK && !seen; i++) begin
         tick(); k++;
         if (k > PD && m_busy) seen = 1;
      end
      n_chk++;
      if (!seen || {r, g, b} !== e) begin n_err++; $display("FAIL %s got %h exp %h", nm, {r, g, b}, e); end
   endtask

   task automatic test_layers();
      logic [31:0] d;
      layer_color = {12'h0F0, 12'hF00, 12'($urandom)};
      while (cur_v() != 1) tick();
      wr(2'd0, 32'h7);
      wr(2'd3, 32'h00F);
      rd(2'd1, d);
      n_chk++; if (d[1] !== 1'b1) begin n_err++; $display("FAIL pending_set got %b exp 1", d[1]); end
      while (!vbl_next()) begin
         layer_valid = NL'($urandom);
         tick();
         n_chk++; if ({r, g, b} !== 12'h0) begin n_err++; $display("FAIL pre_vblank_rgb got %h exp 0", {r, g, b}); end
      end
      tick();
      rd(2'd1, d);
      n_chk++; if (d[1] !== 1'b0) begin n_err++; $display("FAIL pending_clear got %b exp 0", d[1]); end
      for (int i = 0; i < FCLK; i++) begin
         layer_valid = NL'($urandom);
         tick();
         n_chk++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL layers t=%0d got %h exp %h", i, obs(), exp_vec()); end
      end
      show_pattern(3'b110, 12'h0F0, "layer2_wins");
      show_pattern(3'b010, 12'hF00, "layer1_only");
      show_pattern(3'b000, 12'h00F, "bg_only");
   endtask

   task automatic test_latency();
      int i = 0;
      layer_valid = '0;
      while (!(column == 10'd3 && row == 10'd1) && i < 2*FCLK) begin tick(); i++; end
      n_chk++; if (column !== 10'd3 || row !== 10'd1) begin n_err++; $display("FAIL latency_reach col=%0d row=%0d exp 3,1", column, row); end
      layer_valid = 3'b100;
      for (int k = 1; k <= PD; k++) begin
         tick();
         n_chk++;
         if ({r, g, b} !== ((k < PD) ? 12'h00F : 12'h0F0)) begin
            n_err++; $display("FAIL latency_rgb k=%0d got %h exp %h", k, {r, g, b}, (k < PD) ? 12'h00F : 12'h0F0);
         end
      end
      while (column != 10'd8 && i < 2*FCLK) begin tick(); i++; end
      for (int k = 1; k <= PD; k++) begin
         tick();
         n_chk++;
         if (busy !== (k < PD)) begin n_err++; $display("FAIL latency_busy k=%0d got %b exp %b", k, busy, k < PD); end
      end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      rst = 1; tick(); rst = 0;
      wr(2'd0, 32'h207);
      while (!vbl_next()) tick();
      tick();
      n_chk++; if (vblank_irq !== 1'b1) begin n_err++; $display("FAIL irq_set got %b exp 1", vblank_irq); end
      rd(2'd1, d);
      n_chk++; if (d[2] !== 1'b1) begin n_err++; $display("FAIL irq_pend got %b exp 1", d[2]); end
      rd(2'd2, d);
      n_chk++; if (d !== 32'd1) begin n_err++; $display("FAIL frame1 got %0d exp 1", d); end
      wr(2'd1, 32'h4);
      n_chk++; if (vblank_irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got %b exp 0", vblank_irq); end
      wr(2'd2, 32'hDEAD);
      while (!vbl_next()) tick();
      wr(2'd1, 32'h4);
      n_chk++; if (vblank_irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins got %b exp 1", vblank_irq); end
      rd(2'd2, d);
      n_chk++; if (d !== 32'd2) begin n_err++; $display("FAIL frame2 got %0d exp 2", d); end
      n_chk++; if (obs() !== exp_vec()) begin n_err++; $display("FAIL irq_model got %h exp %h", obs(), exp_vec()); end
   endtask

   task automatic test_vbl_write();
      logic [31:0] d;
      layer_color = {12'h0F0, 12'hF00, 12'h123};
      while (cur_v() != 2) tick();
      wr(2'd0, 32'h206);
      while (!vbl_next()) tick();
      wr(2'd0, 32'h201);
      rd(2'd1, d);
      n_chk++; if (d[1] !== 1'b1) begin n_err++; $display("FAIL vbl_write_pending got %b exp 1", d[1]); end
      rd(2'd0, d);
      n_chk++; if (d !== 32'h201) begin n_err++; $display("FAIL vbl_write_shadow got %h exp 201", d); end
      show_pattern(3'b011, 12'hF00, "old_shadow_applied");
      while (!vbl_next()) begin
         layer_valid = NL'($urandom);
         tick();
         n_chk++;
         if (obs() !== exp_vec()) begin n_err++; $display("FAIL vbl_write t=%0d got %h exp %h", mt, obs(), exp_vec()); end
      end
      tick();
      rd(2'd1, d);
      n_chk++; if (d[1] !== 1'b0) begin n_err++; $display("FAIL vbl_write_applied got %b exp 0", d[1]); end
      show_pattern(3'b011, 12'h123, "new_shadow_applied");
   endtask

   task automatic test_mid_reset();
      logic [31:0] d;
      while (!(cur_v() == 1 && cur_h() == 4)) tick();
      n_chk++; if (vblank_irq !== 1'b1) begin n_err++; $display("FAIL mid_reset_pre_irq got %b exp 1", vblank_irq); end
      rst = 1; tick();
      n_chk++;
      if (obs() !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0}) begin
         n_err++; $display("FAIL mid_reset_outputs got %h exp %h", obs(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0});
      end
      rd(2'd2, d);
      n_chk++; if (d !== 32'd0) begin n_err++; $display("FAIL mid_reset_frame got %0d exp 0", d); end
      rst = 0;
      for (int k = 1; k < PD; k++) begin
         tick();
         n_chk++; if (column !== 10'd0) begin n_err++; $display("FAIL mid_reset_ce col=%0d exp 0", column); end
      end
      tick();
      n_chk++; if (column !== 10'd1) begin n_err++; $display("FAIL mid_reset_ce col=%0d exp 1", column); end
   endtask

   initial begin
      mt = 0;
      test_reset();
      test_timing();
      test_layers();
      test_latency();
      test_irq();
      test_vbl_write();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/vga_layer_ctrl.md
Name: vga_layer_ctrl

Overview:
Parametrised successor to the fixed 640x480 VGA controller. It generates VGA timing from a single system clock using an internal pixel-enable divider, and composites NLAYER external colour sources by fixed priority over a background colour. It exposes a CPU register file whose control writes take effect only at vblank entry (tear-free), plus a frame counter and a vblank interrupt. It sits between the bus decoder and the text/graph/cursor layer blocks.

Parameters:
PIX_DIV, 4, clk cycles per pixel (>=2)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
NLAYER, 3, number of layer inputs (1..8)
CW, 4, bits per colour channel

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
we_reg  in  1  register write strobe
rd_reg  in  1  register read select
reg_addr  in  2  word address of register
data_in  in  32  write data
data_out  out  32  read data (combinational; 0 when rd_reg=0)
layer_color  in  NLAYER*3*CW  per-layer {r,g,b}; layer i occupies bits [i*3*CW +: 3*CW]
layer_valid  in  NLAYER  layer i pixel is opaque
column  out  10  current pixel x (stage 0)
row  out  10  current pixel y (stage 0)
r, g, b  out  CW each  composited colour
hsync, vsync  out  1 each  sync outputs
busy  out  1  stage-1 pixel is in the active area
vblank_irq  out  1  interrupt level (irq_pend & irq_en)

Behaviour:
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT is defined analogously.
- A divider counts 0..PIX_DIV-1. pix_ce is high for one clk when the divider equals PIX_DIV-1.
- Stage 0: on pix_ce, h increments; at H_TOT-1 it wraps to 0 and v increments; v wraps at V_TOT-1. column/row are the h/v registers.
- Stage 1 (registered on pix_ce, from stage-0 values sampled before increment):
  - busy = (h<H_ACTIVE && v<V_ACTIVE).
  - hsync active while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule on v.
  - RGB selection:
    - 0 if not active or blank_force = 1.
    - Otherwise the highest-index i with en[i] & layer_valid[i].
    - Otherwise bgcolor.
  - Result: colour for (column,row) appears exactly one pixel period after column/row show that coordinate. Layers have PIX_DIV clk cycles to respond.
- Registers:
  - Addr 0 CTRL: [NLAYER-1:0] layer enable, [8] blank_force, [9] irq_en. Writes go to a shadow copy and set `pending`. Reads return the shadow.
  - Addr 1 STATUS: [0] vblank (v>=V_ACTIVE), [1] pending, [2] irq_pend. Writing 1 to bit 2 clears irq_pend. Other bits are ignored.
  - Addr 2 FRAME: 32-bit read-only counter; writes are ignored.
  - Addr 3 BGCOLOR: [3*CW-1:0]; shadowed exactly like CTRL, sharing `pending`.
  - Undefined read bits return 0.
- Vblank entry is the pix_ce cycle where stage-0 advances to v=V_ACTIVE, h=0. In that cycle:
  - The active copies load from the shadow copies if pending; pending clears.
  - FRAME increments (wrapping at 2^32-1 to 0).
  - irq_pend sets.
- Simultaneous events:
  - A CTRL/BGCOLOR write in the vblank-entry cycle: the transfer uses the pre-write shadow, the write lands in the shadow, and pending stays 1.
  - An irq clear in the vblank-entry cycle: set wins.
- Reset (also mid-frame) clears, in the same cycle: divider, h, v, column, row, rgb, busy, all shadow and active registers, pending, irq_pend, FRAME. hsync/vsync go to the inactive level (!SYNC_POL). vblank_irq = 0. The first pix_ce after reset is PIX_DIV clks later.

Test Plan:
- Small timing (PIX_DIV=2, H 8/2/2/2, V 4/1/1/1), run 2 frames -> H_TOT=14 and V_TOT=7; hsync low for pixels 10-11 and vsync low for line 5, each for exactly 4 and 28 clks; column/row return to 0,0 after 196 clks.
- Write CTRL=0x7 and BGCOLOR=0x00F mid-frame; layer1 valid=0xF00, layer2 valid=0x0F0 -> output stays 0 until vblank entry. The next frame shows 0x0F0 on active pixels. With layer2 invalid it shows 0xF00; with none valid it shows 0x00F; blanking pixels are 0.
- Latency check -> rgb and busy for coordinate (3,1) change exactly one pix_ce after column=3,row=1.
- Set irq_en; at vblank entry -> irq_pend=1, vblank_irq=1, FRAME=1. Write STATUS=0x4 -> irq low. Clear write coincident with the next vblank entry -> irq stays high and FRAME=2.
- CTRL write on the exact vblank-entry cycle -> STATUS[1]=1 afterwards; applied only at the following vblank.
- Assert rst mid-active-line with irq pending -> next clk all outputs 0 and syncs inactive; FRAME reads 0; the first pix_ce comes PIX_DIV clks after rst falls.
